sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO that generalises the team's fixed-size synchronous FIFO.
- Configurable data width, depth, and almost-full/almost-empty thresholds.
- Occupancy count output and synchronous flush.
- Selectable standard (registered read) or first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer stages in the same clock domain; verified with the team's interface/monitor bench flow.

Parameters:
- DATA_WIDTH, 16: width of data_in/data_out.
- DEPTH, 8: number of entries; power of 2, >= 4.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop in FWFT mode).
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- wr_ack  out  1  registered; prior-cycle write accepted.
- overflow  out  1  registered; prior-cycle write rejected because full.
- underflow  out  1  registered; prior-cycle read rejected because empty.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow all 0; empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Pointers:
  - Width $clog2(DEPTH); wrap naturally from DEPTH-1 to 0.
  - count is a separate register: +1 on write only, -1 on read only, unchanged when both are accepted.
- Write acceptance: write accepted iff wr_en && !full; mem[wr_ptr] <= data_in; wr_ptr++.
- Read acceptance: read accepted iff rd_en && !empty; rd_ptr++.
- Simultaneous wr_en and rd_en:
  - Full: read accepted, write rejected (overflow=1 next cycle).
  - Empty: write accepted, read rejected (underflow=1 next cycle).
  - Otherwise both are accepted and count is unchanged.
- Status flags:
  - full, empty, almost_full, almost_empty are combinational decodes of the count register, so they update the cycle after the causing edge.
- Handshake outputs (each asserted for exactly one cycle per event, cleared otherwise):
  - wr_ack: set on the edge that accepts a write.
  - overflow: set on the edge that rejects a write.
  - underflow: set on the edge that rejects a read.
- Standard mode (FWFT=0):
  - data_out <= mem[rd_ptr] on an accepted read, so data appears the cycle after rd_en.
  - data_out holds its value otherwise, including while empty.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally whenever !empty; 0 when empty.
  - First word is visible the cycle after its write edge.
  - rd_en pops the current word; the next word is visible the following cycle.
- Flush (synchronous): clears pointers, count, wr_ack/overflow/underflow and data_out to reset values. Flush overrides wr_en/rd_en in the same cycle; those requests are dropped with no ack/overflow/underflow.
- Reset mid-operation: immediate return to reset state; in-flight requests are discarded.
- Parameter check: illegal DEPTH, AF_LEVEL or AE_LEVEL causes a fatal error at elaboration.

Test Plan:
- Reset/flags: DEPTH=8, assert rst_n=0 mid-stream -> count=0, empty=1, almost_empty=1, full=0, data_out=0 with no clock edge needed.
- Fill/overflow: 9 writes of 0x0001..0x0009 -> wr_ack for the first 8; almost_full from count=7; full at count=8; 9th write gives overflow=1 for one cycle, count stays 8.
- Drain/underflow (FWFT=0): 9 reads after fill -> data_out 0x0001..0x0008, each one cycle after rd_en; 9th read gives underflow=1; empty=1.
- Simultaneous boundaries:
  - wr+rd while full -> count 8→7, overflow=1.
  - wr+rd while empty -> count 0→1, underflow=1.
  - wr+rd at count=4 -> count stays 4, data ordering preserved.
- Wrap-around: 20 interleaved writes/reads keeping count in 2..6 -> data_out sequence matches the write order exactly across pointer wrap.
- FWFT/flush:
  - FWFT=1: write 0xABCD to an empty FIFO -> data_out=0xABCD and empty=0 on the next cycle; pop -> empty=1, data_out=0.
  - flush with count=5 and wr_en=1 -> count=0, no wr_ack.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// synchronous flush and a selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    wr_ack,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and at least 4");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $fatal(1, "sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $fatal(1, "sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $fatal(1, "sync_fifo_param: FWFT must be 0 or 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flush swallows any request presented in the same cycle.
    assign wr_accept = wr_en && !full  && !flush;
    assign rd_accept = rd_en && !empty && !flush;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CW'(1);
            end else if (rd_accept && !wr_accept) begin
                count <= count - CW'(1);
            end
        end
    end

    generate
        if (FWFT == 1) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out <= '0;
                end else if (flush) begin
                    data_out <= '0;
                end else if (rd_accept) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule
